serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from one full-adder cell and a
// registered carry. It processes one bit per clock, LSB first. Operands come in
// through a valid/ready handshake. The result is held behind a second
// valid/ready handshake until the consumer takes it.
//
// Optional build feature: define SERIAL_ADDER_OVF_EN to add the 'ovf' output.
// That output is the signed two's-complement overflow flag, equal to the carry
// into the MSB XOR the carry out of the MSB.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // The bit counter needs at least one bit, so WIDTH=1 still gets a legal vector.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    count;

    logic             bit_s;
    logic             carry_nx;
    logic [WIDTH-1:0] sum_nx;

    // Full-adder cell acting on the current LSBs of the operand shift registers.
    always_comb begin
        bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    end

    // The sum register fills from the MSB end. After WIDTH shifts, bit 0 holds
    // the first (LSB) result bit. With WIDTH=1 the new bit is the whole register.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_nx = bit_s;
        end else begin : g_sum_wn
            assign sum_nx = {bit_s, sum[WIDTH-1:1]};
        end
    endgenerate

    // Handshake FSM and serial datapath. All outputs are registered here.
    // NOTE: state and outputs use non-blocking assignments so every register
    // samples pre-edge values; blocking here would let later lines see new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            count     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        count    <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_nx;
                    sum   <= sum_nx;
                    count <= count + CW'(1);
                    if (count == LAST_BIT) begin
                        // Final bit: the carry into the MSB is the pre-edge carry.
                        cout      <= carry_nx;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf       <= carry ^ carry_nx;
`endif
                        count     <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder. It drives two
// instances, WIDTH=8 and WIDTH=1. Expected results come from plain integer
// arithmetic on the operands captured at the accepting edge.
module tb_serial_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    // WIDTH=8 instance signals
    logic       in_valid8  = 1'b0;
    logic       in_ready8;
    logic [7:0] a8         = '0;
    logic [7:0] b8         = '0;
    logic       cin8       = 1'b0;
    logic       out_valid8;
    logic       out_ready8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8;
    logic       busy8;

    // WIDTH=1 instance signals
    logic       in_valid1  = 1'b0;
    logic       in_ready1;
    logic [0:0] a1         = '0;
    logic [0:0] b1         = '0;
    logic       cin1       = 1'b0;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic [0:0] sum1;
    logic       cout1;
    logic       busy1;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf8;
    logic ovf1;
    logic exp_ovf8 = 1'b0;
    logic exp_ovf1 = 1'b0;
    logic got_ovf8 = 1'b0;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp8     = '0;
    logic [1:0] exp1     = '0;
    logic [8:0] got8     = '0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .busy      (busy8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact unsigned sum as a WIDTH+1-bit value.
    function automatic logic [8:0] add_model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int t;
        t = int'(x) + int'(y) + int'(c);
        return 9'(t);
    endfunction

`ifdef SERIAL_ADDER_OVF_EN
    // Reference: signed overflow means the true signed sum lies outside the WIDTH-bit range.
    function automatic logic ovf_model(input int w, input int xs, input int ys, input logic c);
        int t;
        t = xs + ys + int'(c);
        return (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
    endfunction

    function automatic int sext8(input logic [7:0] x);
        return x[7] ? int'(x) - 256 : int'(x);
    endfunction
`endif

    // Compare process: checks each instance against the model on every cycle its result is valid.
    always @(negedge clk) begin
        if (rst_n && out_valid8) begin
            check("sum8_vs_model", {cout8, sum8}, exp8);
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf8_vs_model", ovf8, exp_ovf8);
`endif
        end
        if (rst_n && out_valid1) begin
            check("sum1_vs_model", {cout1, sum1}, exp1);
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf1_vs_model", ovf1, exp_ovf1);
`endif
        end
    end

    // One full WIDTH=8 transaction. Inputs are scrambled while RUN is active,
    // and the result is held for 'hold' cycles of backpressure.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, input int hold);
        int  lat;
        bit  done;
        @(negedge clk);
        check("in_ready8_idle", in_ready8, 1);
        a8        = x;
        b8        = y;
        cin8      = c;
        in_valid8 = 1'b1;
        exp8      = add_model8(x, y, c);
`ifdef SERIAL_ADDER_OVF_EN
        exp_ovf8  = ovf_model(8, sext8(x), sext8(y), c);
`endif
        @(posedge clk);
        #1;
        lat  = 0;
        done = 1'b0;
        for (int k = 1; k <= 12 && !done; k++) begin
            in_valid8  = 1'($urandom_range(0, 1));
            a8         = 8'($urandom);
            b8         = 8'($urandom);
            cin8       = 1'($urandom_range(0, 1));
            out_ready8 = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (out_valid8) begin
                lat  = k;
                done = 1'b1;
            end else begin
                check("busy8_run", {busy8, in_ready8}, 2'b10);
            end
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        check("latency8", lat, 8);
        got8 = {cout8, sum8};
`ifdef SERIAL_ADDER_OVF_EN
        got_ovf8 = ovf8;
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold8_result", {cout8, sum8}, got8);
            check("hold8_flags", {out_valid8, in_ready8, busy8}, 3'b101);
        end
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        check("release8_flags", {out_valid8, in_ready8, busy8}, 3'b010);
        check("release8_keep", {cout8, sum8}, got8);
    endtask

    initial begin
        // Reset assertion and reset state.
        #2 rst_n = 1'b0;
        #1;
        check("rst8_flags", {in_ready8, out_valid8, busy8}, 3'b100);
        check("rst8_result", {cout8, sum8}, 9'h000);
        check("rst1_flags", {in_ready1, out_valid1, busy1}, 3'b100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed vectors.
        op8(8'h5A, 8'h33, 1'b0, 0);
        check("lit_5a_33", got8, 9'h08D);
`ifdef SERIAL_ADDER_OVF_EN
        check("lit_5a_33_ovf", got_ovf8, 1'b1);
`endif
        op8(8'hFF, 8'h01, 1'b0, 1);
        check("lit_ff_01", got8, 9'h100);
`ifdef SERIAL_ADDER_OVF_EN
        check("lit_ff_01_ovf", got_ovf8, 1'b0);
`endif
        op8(8'hFF, 8'hFF, 1'b1, 0);
        check("lit_ff_ff_c", got8, 9'h1FF);
        op8(8'h80, 8'h80, 1'b0, 2);
        check("lit_80_80", got8, 9'h100);
`ifdef SERIAL_ADDER_OVF_EN
        check("lit_80_80_ovf", got_ovf8, 1'b1);
`endif

        // Backpressure: result held for 5 cycles.
        op8(8'h12, 8'h34, 1'b1, 5);
        check("lit_12_34_c", got8, 9'h047);

        // Reset in the middle of RUN, after 3 bits.
        @(negedge clk);
        a8        = 8'hC3;
        b8        = 8'h7E;
        cin8      = 1'b1;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {out_valid8, in_ready8, busy8}, 3'b010);
        check("midrst_result", {cout8, sum8}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'hC3, 8'h7E, 1'b1, 1);
        check("lit_after_rst", got8, 9'h142);

        // Randomized operations with random backpressure.
        for (int n = 0; n < 30; n++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // WIDTH=1 instance: every combination of a, b, cin.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            int         lat;
            v = 3'(i);
            @(negedge clk);
            check("in_ready1_idle", in_ready1, 1);
            a1        = v[2];
            b1        = v[1];
            cin1      = v[0];
            in_valid1 = 1'b1;
            exp1      = 2'(int'(v[2]) + int'(v[1]) + int'(v[0]));
`ifdef SERIAL_ADDER_OVF_EN
            exp_ovf1  = ovf_model(1, -int'(v[2]), -int'(v[1]), v[0]);
`endif
            @(posedge clk);
            #1;
            in_valid1 = 1'b0;
            a1        = ~v[2];
            b1        = ~v[1];
            cin1      = ~v[0];
            lat       = 0;
            for (int k = 1; k <= 5 && lat == 0; k++) begin
                @(posedge clk);
                #1;
                if (out_valid1) lat = k;
            end
            check("latency1", lat, 1);
            check("lit1_sum", {cout1, sum1}, 2'(v[2] + v[1] + v[0]));
            out_ready1 = 1'b1;
            @(posedge clk);
            #1;
            out_ready1 = 1'b0;
            check("release1_flags", {out_valid1, in_ready1, busy1}, 3'b010);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so that a stuck design cannot hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
